// File: rtl/morse_pkg.sv
// Purpose : shared constants for the Morse link: pattern width, gap length,
//           the 8 left-aligned letter patterns (A=000..H=111), FSM encoding.
// Latency : n/a (package).  Backpressure: n/a.
package morse_pkg;

  localparam int PAT_W_DEF   = 12;
  localparam int GAP_LEN_DEF = 3;

  // MSB-first, left-aligned, zero-filled letter patterns.
  localparam logic [11:0] PAT_A = 12'b1011_1000_0000;
  localparam logic [11:0] PAT_B = 12'b1110_1010_1000;
  localparam logic [11:0] PAT_C = 12'b1110_1011_1010;
  localparam logic [11:0] PAT_D = 12'b1110_1010_0000;
  localparam logic [11:0] PAT_E = 12'b1000_0000_0000;
  localparam logic [11:0] PAT_F = 12'b1010_1110_1000;
  localparam logic [11:0] PAT_G = 12'b1110_1110_1000;
  localparam logic [11:0] PAT_H = 12'b1010_1010_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [11:0] pattern_of(input logic [2:0] code);
    logic [11:0] p;
    case (code)
      3'd0:    p = PAT_A;
      3'd1:    p = PAT_B;
      3'd2:    p = PAT_C;
      3'd3:    p = PAT_D;
      3'd4:    p = PAT_E;
      3'd5:    p = PAT_F;
      3'd6:    p = PAT_G;
      default: p = PAT_H;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/morse_pattern_match.sv
// Purpose : reverse-maps a left-aligned 12-bit Morse pattern to its letter code.
// Latency : combinational.  Backpressure: none.
// Ports   : i_q pattern in; o_code letter code; o_hit high when i_q matches a letter.
module morse_pattern_match
  import morse_pkg::*;
(
  input  logic [11:0] i_q,
  output logic [2:0]  o_code,
  output logic        o_hit
);

  always_comb begin
    o_code = '0;
    o_hit  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i_q == pattern_of(3'(i))) begin
        o_code = 3'(i);
        o_hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Purpose : Morse receive path: assembles dot/dash symbols sampled on BitTick,
//           detects the inter-letter gap and emits the decoded letter code.
// Latency : Valid/Error pulse one edge after the edge sampling the last gap zero.
// Backpr. : none; a BitTick arriving in the one-cycle DONE state is dropped.
// Ports   : ClockIn/Resetn clock and async active-low reset; Start resync;
//           BitTick+DotDashIn symbol input; LetterOut/Valid/Error/Busy status.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int PAT_W   = PAT_W_DEF,
  parameter int GAP_LEN = GAP_LEN_DEF
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       BitTick,
  input  logic       DotDashIn,
  output logic [2:0] LetterOut,
  output logic       Valid,
  output logic       Error,
  output logic       Busy
);

  localparam int IDX_W = $clog2(PAT_W + 1);
  localparam int ZR_W  = $clog2(GAP_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W);
  localparam logic [ZR_W-1:0]  ZR_GAP  = ZR_W'(GAP_LEN);
  localparam logic [PAT_W-1:0] MSB_ONE = {1'b1, {(PAT_W-1){1'b0}}};

  state_t           r_state,    w_state_nxt;
  logic [PAT_W-1:0] r_q,        w_q_nxt;
  logic [IDX_W-1:0] r_idx,      w_idx_nxt;
  logic [ZR_W-1:0]  r_zero_run, w_zr_nxt;
  logic             r_ovf,      w_ovf_nxt;
  logic [2:0]       r_letter,   w_letter_nxt;
  logic             r_valid,    w_valid_nxt;
  logic             r_error,    w_error_nxt;

  logic [IDX_W-1:0] w_idx_sat;
  logic [ZR_W-1:0]  w_zr_inc;
  logic [2:0]       w_code;
  logic             w_hit;

  morse_pattern_match u_match (
    .i_q    (r_q),
    .o_code (w_code),
    .o_hit  (w_hit)
  );

  assign w_idx_sat = (r_idx == IDX_MAX) ? r_idx : r_idx + 1'b1;
  assign w_zr_inc  = r_zero_run + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_idx_nxt    = r_idx;
    w_zr_nxt     = r_zero_run;
    w_ovf_nxt    = r_ovf;
    w_letter_nxt = r_letter;
    w_valid_nxt  = 1'b0;
    w_error_nxt  = 1'b0;
    if (Start) begin
      w_state_nxt = ST_IDLE;
      w_q_nxt     = '0;
      w_idx_nxt   = '0;
      w_zr_nxt    = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Leading zeros are silence; only a 1 opens a letter.
          if (BitTick && DotDashIn) begin
            w_state_nxt = ST_RECV;
            w_q_nxt     = MSB_ONE;
            w_idx_nxt   = IDX_W'(1);
            w_zr_nxt    = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        ST_RECV: begin
          if (BitTick) begin
            w_idx_nxt = w_idx_sat;
            if (DotDashIn) begin
              // Zeros are already in place, so only 1s need writing.
              if (r_idx < IDX_MAX) w_q_nxt = r_q | (MSB_ONE >> r_idx);
              else                 w_ovf_nxt = 1'b1;
              w_zr_nxt = '0;
            end else begin
              w_zr_nxt = w_zr_inc;
              if (w_zr_inc == ZR_GAP) w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          if (w_hit && !r_ovf) begin
            w_letter_nxt = w_code;
            w_valid_nxt  = 1'b1;
          end else begin
            w_error_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= ST_IDLE;
      r_q        <= '0;
      r_idx      <= '0;
      r_zero_run <= '0;
      r_ovf      <= 1'b0;
      r_letter   <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_q        <= w_q_nxt;
      r_idx      <= w_idx_nxt;
      r_zero_run <= w_zr_nxt;
      r_ovf      <= w_ovf_nxt;
      r_letter   <= w_letter_nxt;
      r_valid    <= w_valid_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign LetterOut = r_letter;
  assign Valid     = r_valid;
  assign Error     = r_error;
  assign Busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Purpose : directed self-checking bench for morse_decoder with a symbol-queue model.
// Latency : model predicts Valid/Error one edge after the last gap zero is sampled.
// Backpr. : n/a; stimulus keeps BitTick four clocks apart.
module tb_morse_decoder;

  localparam int GAP = 3;

  logic       ClockIn;
  logic       Resetn;
  logic       Start;
  logic       BitTick;
  logic       DotDashIn;
  logic [2:0] LetterOut;
  logic       Valid;
  logic       Error;
  logic       Busy;

  int total = 0;
  int bad   = 0;
  int nvalid = 0;
  int nerr   = 0;

  morse_decoder dut (
    .ClockIn   (ClockIn),
    .Resetn    (Resetn),
    .Start     (Start),
    .BitTick   (BitTick),
    .DotDashIn (DotDashIn),
    .LetterOut (LetterOut),
    .Valid     (Valid),
    .Error     (Error),
    .Busy      (Busy)
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  // ---------------- model ----------------
  string pats [8] = '{"10111", "111010101", "11101011101", "1110101",
                      "1", "101011101", "111011101", "1010101"};
  bit         sym[$];
  bit         m_active = 0;
  bit         m_pend   = 0;
  logic [2:0] m_letter = 3'b000;
  logic       m_valid  = 1'b0;
  logic       m_error  = 1'b0;
  logic       m_busy   = 1'b0;

  task automatic decide();
    int    len;
    string s;
    bit    found;
    len   = sym.size() - GAP;
    found = 0;
    if (len <= 12) begin
      s = "";
      for (int i = 0; i < len; i++) s = {s, sym[i] ? "1" : "0"};
      for (int k = 0; k < 8; k++) begin
        if (s == pats[k]) begin
          found    = 1;
          m_letter = 3'(k);
        end
      end
    end
    if (found) m_valid = 1'b1;
    else       m_error = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge ClockIn or negedge Resetn);
      if (!Resetn) begin
        m_active = 0; m_pend = 0; sym.delete();
        m_letter = 3'b000; m_valid = 1'b0; m_error = 1'b0;
      end else begin
        m_valid = 1'b0;
        m_error = 1'b0;
        if (Start) begin
          m_active = 0; m_pend = 0; sym.delete();
        end else if (m_pend) begin
          m_pend = 0;
          decide();
        end else if (BitTick) begin
          if (!m_active) begin
            if (DotDashIn) begin
              m_active = 1;
              sym.delete();
              sym.push_back(1'b1);
            end
          end else begin
            int  n;
            bit  gap;
            sym.push_back(DotDashIn);
            n   = sym.size();
            gap = (n > GAP);
            for (int k = 1; k <= GAP; k++) if (n > GAP && sym[n-k]) gap = 0;
            if (gap) begin
              m_active = 0;
              m_pend   = 1;
            end
          end
        end
      end
      m_busy = m_active || m_pend;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge ClockIn);
      check("cyc_valid",  Valid,     m_valid);
      check("cyc_error",  Error,     m_error);
      check("cyc_busy",   Busy,      m_busy);
      check("cyc_letter", LetterOut, m_letter);
      if (Valid === 1'b1) nvalid++;
      if (Error === 1'b1) nerr++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge ClockIn);
    #1;
  endtask

  task automatic tick(input logic b);
    BitTick   = 1'b1;
    DotDashIn = b;
    step();
    BitTick   = 1'b0;
    step(); step(); step();
  endtask

  task automatic send(input string p);
    for (int i = 0; i < p.len(); i++) tick(p.getc(i) == "1");
    for (int k = 0; k < GAP; k++) tick(1'b0);
  endtask

  int v0, e0;

  initial begin
    Resetn = 1'b0; Start = 1'b0; BitTick = 1'b0; DotDashIn = 1'b0;
    #1;
    check("rst_letter", LetterOut, 3'b000);
    check("rst_valid",  Valid, 1'b0);
    check("rst_error",  Error, 1'b0);
    check("rst_busy",   Busy,  1'b0);
    repeat (3) step();
    Resetn = 1'b1;
    step();

    // A
    v0 = nvalid; e0 = nerr;
    BitTick = 1'b1; DotDashIn = 1'b1;
    step();
    BitTick = 1'b0;
    check("a_busy_first", Busy, 1'b1);
    step(); step(); step();
    send("0111");
    check("a_nvalid", nvalid - v0, 1);
    check("a_nerr",   nerr - e0,   0);
    check("a_letter", LetterOut, 3'b000);
    check("a_busy_end", Busy, 1'b0);

    // C then H
    v0 = nvalid;
    send("11101011101");
    check("c_letter", LetterOut, 3'b010);
    send("1010101");
    check("h_letter", LetterOut, 3'b111);
    check("ch_nvalid", nvalid - v0, 2);

    // E with explicit latency checks
    v0 = nvalid;
    tick(1'b1); tick(1'b0); tick(1'b0);
    BitTick = 1'b1; DotDashIn = 1'b0;
    step();
    check("e_lat0_valid", Valid, 1'b0);
    check("e_lat0_busy",  Busy,  1'b1);
    BitTick = 1'b0;
    step();
    check("e_lat1_valid",  Valid, 1'b1);
    check("e_lat1_letter", LetterOut, 3'b100);
    check("e_lat1_busy",   Busy,  1'b0);
    step(); step();

    // 1 00 1: short zero run is part of the letter
    v0 = nvalid; e0 = nerr;
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b1);
    check("run2_busy",   Busy, 1'b1);
    check("run2_nvalid", nvalid - v0, 0);
    tick(1'b0); tick(1'b0); tick(1'b0);
    check("p1001_nerr", nerr - e0, 1);

    // unknown pattern and overflow
    v0 = nvalid; e0 = nerr;
    send("1111");
    check("unk_nerr",   nerr - e0, 1);
    check("unk_letter", LetterOut, 3'b100);
    send("1111111111111");
    check("ovf_nerr",   nerr - e0, 2);
    check("err_nvalid", nvalid - v0, 0);

    // async reset mid-letter
    tick(1'b1); tick(1'b0); tick(1'b1);
    Resetn = 1'b0;
    #1;
    check("mid_rst_letter", LetterOut, 3'b000);
    check("mid_rst_busy",   Busy, 1'b0);
    step(); step();
    Resetn = 1'b1;
    step();

    // Start mid-letter, then G
    send("1110101");
    check("d_letter", LetterOut, 3'b011);
    v0 = nvalid; e0 = nerr;
    tick(1'b1); tick(1'b1);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("start_busy",   Busy, 1'b0);
    check("start_letter", LetterOut, 3'b011);
    step(); step();
    check("start_nopulse", (nvalid - v0) + (nerr - e0), 0);
    send("111011101");
    check("g_letter", LetterOut, 3'b110);

    // DotDashIn toggling without BitTick
    v0 = nvalid;
    for (int i = 0; i < 20; i++) begin
      DotDashIn = ~DotDashIn;
      step();
    end
    check("idle_busy",   Busy, 1'b0);
    check("idle_nvalid", nvalid - v0, 0);
    check("idle_letter", LetterOut, 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
